// File: rtl/counter_seq_ctrl_if.sv
// counter_seq_ctrl_if: command/status bundle between the sequencer and the counter path
interface counter_seq_ctrl_if #(parameter int W = 3);
    logic         iStart, iPause, iClear, iLoad, iDir;
    logic [W-1:0] iLoadVal, iStopAt, iQ;
    logic         oEn, oUp, oClr, oLoad, oDone;
    logic [W-1:0] oLoadVal;
    logic [1:0]   oState;
    modport master (
        output iStart, iPause, iClear, iLoad, iDir, iLoadVal, iStopAt, iQ,
        input  oEn, oUp, oClr, oLoad, oDone, oLoadVal, oState
    );
    modport slave (
        input  iStart, iPause, iClear, iLoad, iDir, iLoadVal, iStopAt, iQ,
        output oEn, oUp, oClr, oLoad, oDone, oLoadVal, oState
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: run/pause/clear sequencer issuing prescaled enable, clear, load and direction
module counter_seq_ctrl #(
    parameter int W       = 3,
    parameter int DIV     = 4,
    parameter int ONESHOT = 1
) (
    input logic               CLK,
    input logic               rst,
    counter_seq_ctrl_if.slave bus
);
    localparam int PW = $clog2(DIV) + 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;
    state_t        r_state, w_state;
    logic [PW-1:0] r_pre, w_pre;
    logic          r_en, r_clr, r_load, r_up, r_done;
    logic          w_en, w_clr, w_load;
    logic [W-1:0]  r_load_val;
    always_comb begin
        w_state = r_state;
        w_pre   = r_pre;
        w_en    = 1'b0;
        w_clr   = 1'b0;
        w_load  = 1'b0;
        if (bus.iClear) begin
            w_clr   = 1'b1;
            w_state = IDLE;
            w_pre   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.iLoad) w_load = 1'b1;
                    else if (bus.iStart) begin
                        w_state = RUN;
                        w_pre   = '0;
                    end
                end
                RUN: begin
                    // terminal detect is skipped while oEn is out: iQ has not stepped yet
                    if (bus.iPause) w_state = PAUSE;
                    else if (ONESHOT != 0 && !r_en && bus.iQ == bus.iStopAt) w_state = DONE;
                    else if (r_pre == LAST) begin
                        w_en  = 1'b1;
                        w_pre = '0;
                    end else w_pre = r_pre + PW'(1);
                end
                PAUSE: begin
                    if (bus.iLoad) w_load = 1'b1;
                    else if (bus.iStart) w_state = RUN;
                end
                default: begin
                    if (bus.iLoad) w_load = 1'b1;
                    else if (bus.iStart) begin
                        w_state = RUN;
                        w_pre   = '0;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pre      <= '0;
            r_en       <= 1'b0;
            r_clr      <= 1'b0;
            r_load     <= 1'b0;
            r_load_val <= '0;
            r_up       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state;
            r_pre   <= w_pre;
            r_en    <= w_en;
            r_clr   <= w_clr;
            r_load  <= w_load;
            r_done  <= (w_state == DONE);
            if (w_load) r_load_val <= bus.iLoadVal;
            if (r_state != RUN) r_up <= bus.iDir;
        end
    end
    assign bus.oEn      = r_en;
    assign bus.oUp      = r_up;
    assign bus.oClr     = r_clr;
    assign bus.oLoad    = r_load;
    assign bus.oLoadVal = r_load_val;
    assign bus.oState   = r_state;
    assign bus.oDone    = r_done;
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed checks of a free-running and a one-shot sequencer, each driving a counter model
module tb_counter_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    counter_seq_ctrl_if #(.W(3)) fa ();
    counter_seq_ctrl_if #(.W(3)) oa ();
    counter_seq_ctrl #(.W(3), .DIV(4), .ONESHOT(0)) u_free (.CLK(clk), .rst(rst), .bus(fa.slave));
    counter_seq_ctrl #(.W(3), .DIV(4), .ONESHOT(1)) u_one  (.CLK(clk), .rst(rst), .bus(oa.slave));
    // counter models: step on the edge that samples oEn, wrap mod 8
    always @(posedge clk or posedge rst) begin
        if (rst) fa.iQ <= 3'd0;
        else if (fa.oClr) fa.iQ <= 3'd0;
        else if (fa.oLoad) fa.iQ <= fa.oLoadVal;
        else if (fa.oEn) fa.iQ <= fa.oUp ? fa.iQ + 3'd1 : fa.iQ - 3'd1;
    end
    always @(posedge clk or posedge rst) begin
        if (rst) oa.iQ <= 3'd0;
        else if (oa.oClr) oa.iQ <= 3'd0;
        else if (oa.oLoad) oa.iQ <= oa.oLoadVal;
        else if (oa.oEn) oa.iQ <= oa.oUp ? oa.iQ + 3'd1 : oa.iQ - 3'd1;
    end
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic clear_free();
        fa.iClear = 1'b1;
        tick(1);
        fa.iClear = 1'b0;
        tick(1);
    endtask
    task automatic test_reset();
        fa.iDir = 1'b0;
        oa.iDir = 1'b0;
        tick(2);
        checks++; if (fa.oState !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", fa.oState); end
        checks++; if (fa.oUp !== 1'b1) begin errors++; $display("FAIL reset_up got %b exp 1", fa.oUp); end
        checks++; if ({fa.oEn, fa.oClr, fa.oLoad, fa.oDone} !== 4'b0) begin errors++; $display("FAIL reset_strobes got %b exp 0000", {fa.oEn, fa.oClr, fa.oLoad, fa.oDone}); end
        checks++; if (fa.oLoadVal !== 3'd0) begin errors++; $display("FAIL reset_loadval got %0d exp 0", fa.oLoadVal); end
        checks++; if ({oa.oState, oa.oUp, oa.oDone} !== 4'b0010) begin errors++; $display("FAIL reset_oneshot got %b exp 0010", {oa.oState, oa.oUp, oa.oDone}); end
        fa.iDir = 1'b1;
        oa.iDir = 1'b1;
        rst = 1'b0;
        tick(1);
    endtask
    task automatic test_free_run();
        int first = -1;
        int strobes = 0;
        int off_phase = 0;
        bit wrapped = 1'b0;
        logic [2:0] prev;
        fa.iStart = 1'b1;
        tick(1);
        fa.iStart = 1'b0;
        checks++; if (fa.oState !== 2'b01 || fa.oEn !== 1'b0) begin errors++; $display("FAIL free_enter got state %b en %b exp 01 0", fa.oState, fa.oEn); end
        for (int i = 1; i <= 64; i++) begin
            prev = fa.iQ;
            tick(1);
            if (prev == 3'd7 && fa.iQ == 3'd0) wrapped = 1'b1;
            if (fa.oEn) begin
                strobes++;
                if (first < 0) first = i;
                if (i % 4 != 0) off_phase++;
            end
        end
        checks++; if (first != 4) begin errors++; $display("FAIL free_first_en got %0d exp 4", first); end
        checks++; if (strobes != 16) begin errors++; $display("FAIL free_strobes got %0d exp 16", strobes); end
        checks++; if (off_phase != 0) begin errors++; $display("FAIL free_phase got %0d exp 0", off_phase); end
        checks++; if (!wrapped) begin errors++; $display("FAIL free_wrap got %b exp 1", wrapped); end
        checks++; if (fa.iQ !== 3'd7) begin errors++; $display("FAIL free_q got %0d exp 7", fa.iQ); end
        fa.iClear = 1'b1;
        tick(1);
        fa.iClear = 1'b0;
        checks++; if (fa.oClr !== 1'b1 || fa.oState !== 2'b00) begin errors++; $display("FAIL free_clear got clr %b state %b exp 1 00", fa.oClr, fa.oState); end
        tick(1);
        checks++; if (fa.oClr !== 1'b0 || fa.iQ !== 3'd0) begin errors++; $display("FAIL free_clear_done got clr %b q %0d exp 0 0", fa.oClr, fa.iQ); end
    endtask
    task automatic test_pause();
        int en_seen = 0;
        fa.iStart = 1'b1;
        tick(1);
        fa.iStart = 1'b0;
        tick(2);
        fa.iPause = 1'b1;
        tick(1);
        checks++; if (fa.oState !== 2'b10) begin errors++; $display("FAIL pause_state got %b exp 10", fa.oState); end
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (fa.oEn) en_seen++;
        end
        fa.iPause = 1'b0;
        checks++; if (en_seen != 0 || fa.iQ !== 3'd0) begin errors++; $display("FAIL pause_hold got en %0d q %0d exp 0 0", en_seen, fa.iQ); end
        fa.iStart = 1'b1;
        tick(1);
        checks++; if (fa.oState !== 2'b01 || fa.oEn !== 1'b0) begin errors++; $display("FAIL resume_state got %b en %b exp 01 0", fa.oState, fa.oEn); end
        tick(1);
        checks++; if (fa.oEn !== 1'b0) begin errors++; $display("FAIL resume_pre3 got %b exp 0", fa.oEn); end
        tick(1);
        checks++; if (fa.oEn !== 1'b1) begin errors++; $display("FAIL resume_tick got %b exp 1", fa.oEn); end
        tick(1);
        checks++; if (fa.oEn !== 1'b0 || fa.iQ !== 3'd1) begin errors++; $display("FAIL resume_single got en %b q %0d exp 0 1", fa.oEn, fa.iQ); end
        fa.iStart = 1'b0;
        clear_free();
    endtask
    task automatic test_priority();
        fa.iClear = 1'b1;
        fa.iLoad = 1'b1;
        fa.iStart = 1'b1;
        fa.iLoadVal = 3'd6;
        tick(1);
        checks++; if ({fa.oClr, fa.oLoad, fa.oState} !== 4'b1000) begin errors++; $display("FAIL prio_all got %b exp 1000", {fa.oClr, fa.oLoad, fa.oState}); end
        tick(1);
        checks++; if (fa.oClr !== 1'b1) begin errors++; $display("FAIL prio_clear_hold got %b exp 1", fa.oClr); end
        fa.iClear = 1'b0;
        fa.iStart = 1'b0;
        tick(1);
        checks++; if (fa.oLoad !== 1'b1 || fa.oLoadVal !== 3'd6 || fa.oState !== 2'b00) begin errors++; $display("FAIL load_idle got ld %b val %0d st %b exp 1 6 00", fa.oLoad, fa.oLoadVal, fa.oState); end
        fa.iLoad = 1'b0;
        tick(1);
        checks++; if (fa.iQ !== 3'd6 || fa.oLoad !== 1'b0) begin errors++; $display("FAIL load_q got q %0d ld %b exp 6 0", fa.iQ, fa.oLoad); end
        fa.iStart = 1'b1;
        tick(1);
        fa.iStart = 1'b0;
        fa.iLoad = 1'b1;
        fa.iLoadVal = 3'd3;
        tick(1);
        fa.iLoad = 1'b0;
        checks++; if (fa.oLoad !== 1'b0 || fa.oState !== 2'b01) begin errors++; $display("FAIL load_in_run got ld %b st %b exp 0 01", fa.oLoad, fa.oState); end
        clear_free();
    endtask
    task automatic test_direction();
        fa.iDir = 1'b0;
        tick(1);
        checks++; if (fa.oUp !== 1'b0) begin errors++; $display("FAIL dir_idle got %b exp 0", fa.oUp); end
        fa.iStart = 1'b1;
        tick(1);
        fa.iStart = 1'b0;
        fa.iDir = 1'b1;
        tick(1);
        checks++; if (fa.oUp !== 1'b0) begin errors++; $display("FAIL dir_frozen got %b exp 0", fa.oUp); end
        tick(4);
        checks++; if (fa.iQ !== 3'd7) begin errors++; $display("FAIL dir_down1 got %0d exp 7", fa.iQ); end
        tick(4);
        checks++; if (fa.iQ !== 3'd6) begin errors++; $display("FAIL dir_down2 got %0d exp 6", fa.iQ); end
        fa.iPause = 1'b1;
        tick(1);
        fa.iPause = 1'b0;
        checks++; if (fa.oUp !== 1'b0) begin errors++; $display("FAIL dir_pause_edge got %b exp 0", fa.oUp); end
        tick(1);
        checks++; if (fa.oUp !== 1'b1) begin errors++; $display("FAIL dir_paused got %b exp 1", fa.oUp); end
        clear_free();
    endtask
    task automatic test_oneshot();
        int strobes = 0;
        int done_at = -1;
        oa.iStopAt = 3'd5;
        oa.iStart = 1'b1;
        tick(1);
        oa.iStart = 1'b0;
        for (int i = 1; i <= 40 && done_at < 0; i++) begin
            tick(1);
            if (oa.oEn) strobes++;
            if (oa.oState == 2'b11) done_at = i;
        end
        checks++; if (done_at != 22) begin errors++; $display("FAIL oneshot_done_at got %0d exp 22", done_at); end
        checks++; if (strobes != 5 || oa.iQ !== 3'd5) begin errors++; $display("FAIL oneshot_count got en %0d q %0d exp 5 5", strobes, oa.iQ); end
        checks++; if (oa.oDone !== 1'b1) begin errors++; $display("FAIL oneshot_flag got %b exp 1", oa.oDone); end
        tick(3);
        checks++; if (oa.oState !== 2'b11 || oa.iQ !== 3'd5 || oa.oEn !== 1'b0) begin errors++; $display("FAIL oneshot_stay got st %b q %0d en %b exp 11 5 0", oa.oState, oa.iQ, oa.oEn); end
        oa.iStart = 1'b1;
        tick(1);
        oa.iStart = 1'b0;
        checks++; if (oa.oState !== 2'b01 || oa.oDone !== 1'b0) begin errors++; $display("FAIL at_stop_run got st %b done %b exp 01 0", oa.oState, oa.oDone); end
        tick(1);
        checks++; if (oa.oState !== 2'b11 || oa.iQ !== 3'd5) begin errors++; $display("FAIL at_stop_done got st %b q %0d exp 11 5", oa.oState, oa.iQ); end
        oa.iStopAt = 3'd7;
        oa.iStart = 1'b1;
        tick(1);
        oa.iStart = 1'b0;
        tick(4);
        checks++; if (oa.oEn !== 1'b1) begin errors++; $display("FAIL restart_en got %b exp 1", oa.oEn); end
        tick(1);
        checks++; if (oa.iQ !== 3'd6) begin errors++; $display("FAIL restart_q got %0d exp 6", oa.iQ); end
    endtask
    task automatic test_async_reset();
        fa.iDir = 1'b0;
        fa.iLoad = 1'b1;
        fa.iLoadVal = 3'd5;
        tick(1);
        fa.iLoad = 1'b0;
        fa.iStart = 1'b1;
        tick(1);
        fa.iStart = 1'b0;
        tick(2);
        #2 rst = 1'b1;
        #1;
        checks++; if ({fa.oState, fa.oUp, fa.oLoadVal} !== 6'b001000) begin errors++; $display("FAIL async_free got %b exp 001000", {fa.oState, fa.oUp, fa.oLoadVal}); end
        checks++; if ({oa.oState, oa.oEn, oa.oDone} !== 4'b0) begin errors++; $display("FAIL async_one got %b exp 0000", {oa.oState, oa.oEn, oa.oDone}); end
        #2 rst = 1'b0;
        fa.iDir = 1'b1;
        tick(1);
    endtask
    initial begin
        {fa.iStart, fa.iPause, fa.iClear, fa.iLoad} = 4'b0;
        {oa.iStart, oa.iPause, oa.iClear, oa.iLoad} = 4'b0;
        fa.iDir = 1'b1;
        oa.iDir = 1'b1;
        fa.iLoadVal = 3'd0;
        oa.iLoadVal = 3'd0;
        fa.iStopAt = 3'd0;
        oa.iStopAt = 3'd0;
        test_reset();
        test_free_run();
        test_pause();
        test_priority();
        test_direction();
        test_oneshot();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
